// File: rtl/multi_debouncer_if.sv
// -----------------------------------------------------------------------------
// multi_debouncer_if
//   Bundles the debounce enable, raw inputs and all per-channel results of
//   multi_debouncer so the block can be wired with a single port.
//
//   Signals (CHANNELS wide unless noted):
//     en      1 bit   debounce enable; counting freezes while low
//     din             raw asynchronous inputs
//     dout            debounced levels
//     rise            one-cycle pulse on dout 0->1
//     fall            one-cycle pulse on dout 1->0
//     stable          candidate equals dout and its counter is saturated
//     busy    1 bit   some channel has a candidate different from dout
//
//   Modports:
//     master  drives en/din, observes results (user logic or testbench)
//     slave   the debouncer itself
// -----------------------------------------------------------------------------
interface multi_debouncer_if #(
    parameter int CHANNELS = 2
);
    logic                en;
    logic [CHANNELS-1:0] din;
    logic [CHANNELS-1:0] dout;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] stable;
    logic                busy;

    modport master (
        output en,
        output din,
        input  dout,
        input  rise,
        input  fall,
        input  stable,
        input  busy
    );

    modport slave (
        input  en,
        input  din,
        output dout,
        output rise,
        output fall,
        output stable,
        output busy
    );
endinterface

// File: rtl/multi_debouncer.sv
// -----------------------------------------------------------------------------
// multi_debouncer
//   CHANNELS independent debouncers (e.g. PS/2 clock and data). Each raw input
//   is brought in through a 2-flop synchronizer; a channel's output follows
//   the synchronized level only after that level has been seen unchanged for
//   DELAY+1 enabled cycles. Any change restarts the count at the new level.
//
//   Ports:
//     clk    single clock for all logic
//     rst_n  asynchronous active-low reset; everything returns to INIT
//     bus    multi_debouncer_if.slave: en, din in; dout, rise, fall,
//            stable, busy out (all outputs registered)
//
//   Parameters:
//     CHANNELS  number of channels, 1..32
//     DELAY     stable-sample count before an output may change, 1..65535
//     INIT      per-channel reset level (idle-high by default)
// -----------------------------------------------------------------------------
module multi_debouncer #(
    parameter int                  CHANNELS = 2,
    parameter int                  DELAY    = 19,
    parameter logic [CHANNELS-1:0] INIT     = '1
) (
    input logic              clk,
    input logic              rst_n,
    multi_debouncer_if.slave bus
);

    localparam int               CNT_W   = $clog2(DELAY + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DELAY);

    // Saturating increment: the counter parks at DELAY and never wraps.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        if (c >= CNT_MAX) return CNT_MAX;
        return c + 1'b1;
    endfunction

    logic [CHANNELS-1:0] s1;
    logic [CHANNELS-1:0] s2;
    logic [CHANNELS-1:0] cand;
    logic [CHANNELS-1:0] dout;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] stable;
    logic                busy;
    logic [CNT_W-1:0]    cnt [CHANNELS];

    logic [CHANNELS-1:0] cand_nxt;
    logic [CHANNELS-1:0] dout_nxt;
    logic [CHANNELS-1:0] rise_nxt;
    logic [CHANNELS-1:0] fall_nxt;
    logic [CHANNELS-1:0] stable_nxt;
    logic                busy_nxt;
    logic [CNT_W-1:0]    cnt_nxt [CHANNELS];

    // Synchronizer: the only logic that touches the raw inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= INIT;
            s2 <= INIT;
        end else begin
            s1 <= bus.din;
            s2 <= s1;
        end
    end

    // Per-channel candidate/counter update. A level change reloads the
    // candidate even while disabled, so the count restarts from the level
    // actually present once enable returns.
    always_comb begin
        cand_nxt   = cand;
        dout_nxt   = dout;
        rise_nxt   = '0;
        fall_nxt   = '0;
        stable_nxt = '0;
        cnt_nxt    = cnt;
        for (int i = 0; i < CHANNELS; i++) begin
            if (s2[i] != cand[i]) begin
                cand_nxt[i] = s2[i];
                cnt_nxt[i]  = '0;
            end else if (bus.en) begin
                cnt_nxt[i] = sat_inc(cnt[i]);
                if (cnt[i] == CNT_MAX) begin
                    dout_nxt[i] = cand[i];
                    rise_nxt[i] = cand[i] & ~dout[i];
                    fall_nxt[i] = ~cand[i] & dout[i];
                end
            end
            // Status is computed from next-state values so it lines up with
            // the registered dout/cand it describes.
            stable_nxt[i] = (cand_nxt[i] == dout_nxt[i]) && (cnt_nxt[i] == CNT_MAX);
        end
        busy_nxt = |(cand_nxt ^ dout_nxt);
    end

    // Candidate, counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand   <= INIT;
            dout   <= INIT;
            rise   <= '0;
            fall   <= '0;
            stable <= '1;
            busy   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt[i] <= CNT_MAX;
            end
        end else begin
            cand   <= cand_nxt;
            dout   <= dout_nxt;
            rise   <= rise_nxt;
            fall   <= fall_nxt;
            stable <= stable_nxt;
            busy   <= busy_nxt;
            cnt    <= cnt_nxt;
        end
    end

    assign bus.dout   = dout;
    assign bus.rise   = rise;
    assign bus.fall   = fall;
    assign bus.stable = stable;
    assign bus.busy   = busy;

endmodule

// File: tb/tb_multi_debouncer.sv
// -----------------------------------------------------------------------------
// tb_multi_debouncer
//   Self-checking bench for multi_debouncer (CHANNELS=2, DELAY=3, INIT=2'b11).
//   A behavioural model tracks, per channel, the synchronized level and how
//   many enabled cycles it has persisted; the output follows once that run
//   exceeds DELAY. Directed scenarios are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_multi_debouncer;
    localparam int            CH  = 2;
    localparam int            DLY = 3;
    localparam logic [CH-1:0] INI = 2'b11;

    logic clk;
    logic rst_n;

    multi_debouncer_if #(.CHANNELS(CH)) bus ();

    multi_debouncer #(
        .CHANNELS(CH),
        .DELAY   (DLY),
        .INIT    (INI)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [CH-1:0] cur_din;
    logic          cur_en;

    // Reference model state
    bit [CH-1:0] m_s1, m_s2, m_lvl, m_dout, m_rise, m_fall;
    int          m_run [CH];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_s1   = INI;
        m_s2   = INI;
        m_lvl  = INI;
        m_dout = INI;
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < CH; i++) m_run[i] = DLY;
    endfunction

    // One clock edge: act on the level that had already crossed the
    // synchronizer, then shift the new raw sample in.
    function automatic void model_step(input bit [CH-1:0] din, input bit en);
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < CH; i++) begin
            if (m_s2[i] != m_lvl[i]) begin
                m_lvl[i] = m_s2[i];
                m_run[i] = 0;
            end else if (en) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] > DLY && m_dout[i] != m_lvl[i]) begin
                    if (m_lvl[i]) m_rise[i] = 1'b1;
                    else          m_fall[i] = 1'b1;
                    m_dout[i] = m_lvl[i];
                end
            end
        end
        m_s2 = m_s1;
        m_s1 = din;
    endfunction

    task automatic compare_all();
        logic [CH-1:0] exp_stable;
        for (int i = 0; i < CH; i++)
            exp_stable[i] = (m_lvl[i] == m_dout[i]) && (m_run[i] >= DLY);
        check_val("dout",   32'(bus.dout),   32'(m_dout));
        check_val("rise",   32'(bus.rise),   32'(m_rise));
        check_val("fall",   32'(bus.fall),   32'(m_fall));
        check_val("stable", 32'(bus.stable), 32'(exp_stable));
        check_val("busy",   32'(bus.busy),   32'(|(m_lvl ^ m_dout)));
    endtask

    task automatic edge_check();
        @(posedge clk);
        model_step(cur_din, cur_en);
        #1 compare_all();
    endtask

    task automatic tick();
        @(negedge clk);
        bus.din = cur_din;
        bus.en  = cur_en;
        edge_check();
    endtask

    task automatic ticks(input int k);
        for (int j = 0; j < k; j++) tick();
    endtask

    // Asserts reset between edges, checks outputs at once and across an edge,
    // then releases it and checks the first edge after release.
    task automatic do_reset();
        @(negedge clk);
        bus.din = cur_din;
        bus.en  = cur_en;
        rst_n   = 1'b0;
        #1 model_reset();
        compare_all();
        @(posedge clk);
        #1 compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        edge_check();
    endtask

    // Ticks until dout[ch] reaches tgt; n is the edge count including 'start'
    // edges already taken. Bounded so a stuck output still ends the run.
    task automatic run_until(input int ch, input logic tgt, input int start, output int n);
        n = start;
        while (n < 40 && bus.dout[ch] !== tgt) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int  n;
        bit  saw_busy;

        rst_n   = 1'b1;
        cur_din = 2'b11;
        cur_en  = 1'b1;
        bus.din = cur_din;
        bus.en  = cur_en;
        model_reset();

        // Reset with idle-high inputs
        do_reset();
        ticks(4);

        // Channel 0 falls and holds
        cur_din = 2'b10;
        run_until(0, 1'b0, 0, n);
        check_val("lat_fall0", 32'(n), 32'd7);
        ticks(4);

        // Short low excursion on channel 0 is rejected
        cur_din = 2'b11;
        ticks(10);
        saw_busy = 1'b0;
        cur_din  = 2'b10;
        for (int j = 0; j < 3; j++) begin
            tick();
            if (bus.busy) saw_busy = 1'b1;
        end
        cur_din = 2'b11;
        for (int j = 0; j < 10; j++) begin
            tick();
            if (bus.busy) saw_busy = 1'b1;
        end
        check_val("exc_busy_seen", 32'(saw_busy), 32'd1);
        check_val("exc_dout",      32'(bus.dout), 32'h3);
        check_val("exc_busy_end",  32'(bus.busy), 32'd0);

        // Channel 1 bounces 0,1,0 then holds 0
        cur_din = 2'b01; ticks(2);
        cur_din = 2'b11; ticks(2);
        cur_din = 2'b01;
        run_until(1, 1'b0, 0, n);
        check_val("lat_bounce1", 32'(n), 32'd7);
        ticks(4);

        // Change while disabled, then enable
        cur_en  = 1'b0;
        cur_din = 2'b00;
        ticks(20);
        check_val("dis_dout", 32'(bus.dout), 32'h1);
        check_val("dis_busy", 32'(bus.busy), 32'd1);
        cur_en = 1'b1;
        run_until(0, 1'b0, 0, n);
        check_val("lat_enable", 32'(n), 32'd4);
        ticks(4);

        // Reset mid-count discards progress
        cur_din = 2'b01;
        ticks(3);
        do_reset();
        run_until(1, 1'b0, 1, n);
        check_val("lat_after_rst", 32'(n), 32'd7);
        ticks(4);

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < CH; i++)
                if ($urandom_range(0, 9) == 0) cur_din[i] = ~cur_din[i];
            cur_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 299) == 0) do_reset();
            else tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent debounce channels, valid range 1..32.
REQ-002 SHALL have parameter DELAY, default 19: stable-sample count required before an output changes, valid range 1..65535.
REQ-003 SHALL have parameter INIT, default all-ones, width CHANNELS: per-channel reset level, so PS/2 clock and data idle high.
REQ-004 SHALL derive counter width internally as clog2(DELAY+1); the width is not a user parameter.
REQ-005 clk  input  1  single clock for all logic; 25 MHz nominal.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 en  input  1  debounce enable; when low, counting is frozen.
REQ-008 din  input  CHANNELS  raw asynchronous inputs.
REQ-009 dout  output  CHANNELS  debounced levels.
REQ-010 rise  output  CHANNELS  one-cycle pulse when the matching dout bit goes 0->1.
REQ-011 fall  output  CHANNELS  one-cycle pulse when the matching dout bit goes 1->0.
REQ-012 stable  output  CHANNELS  high while the channel's candidate level equals dout and its counter is saturated.
REQ-013 busy  output  1  OR over channels of (candidate level != dout).

Function
REQ-014 SHALL pass each din bit through a 2-flop synchronizer (s1, s2); no other logic SHALL sample din directly.
REQ-015 SHALL keep a candidate level cand[i] and counter cnt[i] for each channel, with no sharing between channels.
REQ-016 SHALL load cand[i]<=s2[i] and cnt[i]<=0 on any cycle where s2[i]!=cand[i], regardless of en.
REQ-017 SHALL, when s2[i]==cand[i], en=1 and cnt[i]<DELAY, increment cnt[i] by 1.
REQ-018 SHALL, when s2[i]==cand[i], en=1 and cnt[i]==DELAY, hold cnt[i] at DELAY (saturate, never wrap) and set dout[i]<=cand[i].
REQ-019 SHALL, when en=0, hold cnt[i] and dout[i] unchanged; rise and fall SHALL be 0.
REQ-020 SHALL register rise[i]=1 for exactly one cycle, in the same cycle dout[i] changes 0->1; fall[i] behaves the same way for 1->0.
REQ-021 SHALL never assert rise and fall together for one channel.
REQ-022 Latency: a din change held steady with en=1 SHALL appear on dout at the (DELAY+4)th rising clk edge, counting the first edge that samples it into s1.
REQ-023 SHALL reject, with no dout change and no pulse, any din excursion lasting fewer than DELAY+1 cycles at s2.
REQ-024 A bounce during counting SHALL restart the count from 0 at the new level; dout SHALL keep its previous value throughout.
REQ-025 Channels changing on the same edge SHALL be processed independently, and their pulses MAY coincide.
REQ-026 stable, busy, rise and fall SHALL be registered outputs with no combinational path from din.

Reset
REQ-027 rst_n=0 SHALL immediately set s1, s2, cand and dout to INIT, cnt to DELAY, and rise, fall and busy to 0.
REQ-028 With INIT-level inputs, stable SHALL be all-ones from the first cycle after reset release.
REQ-029 Reset asserted mid-count SHALL discard the pending count; after release, a differing din SHALL need the full REQ-022 latency again.
REQ-030 Reset deassertion SHALL be synchronised externally; this block requires no release-to-first-edge ordering.

Verification (CHANNELS=2, DELAY=3, INIT=2'b11)
REQ-031 Reset, din=2'b11 held -> dout=2'b11, stable=2'b11, busy=0, no pulses.
REQ-032 din[0] 1->0 held -> dout[0]=0 on the 7th edge, fall[0]=1 for that single cycle, dout[1] stays 1.
REQ-033 din[0] low for 3 cycles, then high -> dout[0] stays 1, no pulses, busy=1 then returns to 0.
REQ-034 din[1] bounces 0,1,0 at 2-cycle spacing, then holds 0 -> dout[1] falls exactly 7 edges after the last transition.
REQ-035 en=0 while din[0] changes, held 20 cycles -> dout unchanged, busy=1; after en=1, dout[0] changes 4 edges later.
REQ-036 rst_n pulsed low mid-count -> outputs at INIT immediately; after release, full 7-edge latency.
